store_merge_unit: RTL and testbench

Multi-cycle store path between the MIPS datapath and a word-only data memory. It narrows a 32-bit register value to the byte or halfword selected by the store size and address, and merges it into the addressed memory word by read-modify-write. It is the store-side counterpart of load sign/zero extension. Word stores go straight through; sub-word stores take a read, capture and write sequence, and misaligned requests are rejected.

---
 rtl/store_merge_unit.sv | 197 +++++++++++++++++++
 tb/tb_store_merge_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// store_merge_unit: store path from a 32-bit register value to a word-only
// data memory. Word stores are written directly. Byte and halfword stores
// read the addressed word, merge the selected little-endian lane, and write
// it back. Misaligned or illegal-size requests complete with an error pulse
// and leave memory untouched. All outputs are registered (Moore style).
module store_merge_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  state_e      state_r;
  state_e      state_nxt_s;

  // Request fields captured at acceptance; only the low half of the write
  // data is ever needed after acceptance (word stores use the live input).
  logic [31:0] addr_r;
  logic [15:0] wdata_r;
  logic        is_half_r;

  logic        accept_s;
  logic        ready_nxt_s;
  logic        re_nxt_s;
  logic        we_nxt_s;
  logic        done_nxt_s;
  logic        err_nxt_s;
  logic [31:0] addr_nxt_s;
  logic [31:0] wdata_nxt_s;

  // Replace one little-endian lane of a memory word with store data.
  // Half: lane selected by off[1]. Byte: lane selected by off[1:0].
  function automatic logic [31:0] merge_lane(
    input logic [31:0] word,
    input logic [15:0] data,
    input logic [1:0]  off,
    input logic        is_half
  );
    logic [31:0] res;
    res = word;
    if (is_half) begin
      if (off[1]) begin
        res[31:16] = data;
      end else begin
        res[15:0] = data;
      end
    end else begin
      case (off)
        2'd0:    res[7:0]   = data[7:0];
        2'd1:    res[15:8]  = data[7:0];
        2'd2:    res[23:16] = data[7:0];
        2'd3:    res[31:24] = data[7:0];
        default: res        = word;
      endcase
    end
    return res;
  endfunction

  assign accept_s = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: alignment and size checks happen at acceptance.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (req_size)
            2'b00: state_nxt_s = ST_READ;
            2'b01: begin
              if (req_addr[0]) begin
                state_nxt_s = ST_ERR;
              end else begin
                state_nxt_s = ST_READ;
              end
            end
            2'b10: begin
              if (req_addr[1:0] == 2'b00) begin
                state_nxt_s = ST_WRITE;
              end else begin
                state_nxt_s = ST_ERR;
              end
            end
            default: state_nxt_s = ST_ERR;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ:  state_nxt_s = ST_CAPT;
      ST_CAPT:  state_nxt_s = ST_WRITE;
      ST_WRITE: state_nxt_s = ST_IDLE;
      ST_ERR:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output values for the state being entered; registered below so every
  // output is a clean flop that reflects the current state.
  always_comb begin
    ready_nxt_s = (state_nxt_s == ST_IDLE);
    re_nxt_s    = (state_nxt_s == ST_READ);
    we_nxt_s    = (state_nxt_s == ST_WRITE);
    done_nxt_s  = (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_ERR);
    err_nxt_s   = (state_nxt_s == ST_ERR);
    addr_nxt_s  = 32'h0000_0000;
    wdata_nxt_s = 32'h0000_0000;

    case (state_nxt_s)
      ST_READ, ST_CAPT, ST_WRITE: begin
        if (state_r == ST_IDLE) begin
          addr_nxt_s = {req_addr[31:2], 2'b00};
        end else begin
          addr_nxt_s = {addr_r[31:2], 2'b00};
        end
      end
      default: addr_nxt_s = 32'h0000_0000;
    endcase

    // The mem_wdata flop doubles as the merge buffer: the capture edge
    // loads the read word with the selected lane already replaced.
    if (state_nxt_s == ST_WRITE) begin
      if (state_r == ST_CAPT) begin
        wdata_nxt_s = merge_lane(mem_rdata, wdata_r, addr_r[1:0], is_half_r);
      end else begin
        wdata_nxt_s = req_wdata;
      end
    end else begin
      wdata_nxt_s = 32'h0000_0000;
    end
  end

  // Registered outputs; reset forces all of them low immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
    end else begin
      req_ready <= ready_nxt_s;
      mem_re    <= re_nxt_s;
      mem_we    <= we_nxt_s;
      done      <= done_nxt_s;
      err       <= err_nxt_s;
      mem_addr  <= addr_nxt_s;
      mem_wdata <= wdata_nxt_s;
    end
  end

  // Capture the request so the caller need not hold it after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 16'h0000;
      is_half_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && accept_s) begin
      addr_r    <= req_addr;
      wdata_r   <= req_wdata[15:0];
      is_half_r <= (req_size == 2'b01);
    end else begin
      addr_r    <= addr_r;
      wdata_r   <= wdata_r;
      is_half_r <= is_half_r;
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit: the driver pushes the expected
// outcome of each accepted request (from a byte/half lane arithmetic model
// of memory), and a negedge monitor checks every memory strobe and done.
module tb_store_merge_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] dev_mem [0:255];

  store_merge_unit dut (
    .clk       (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure latency from the accept edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1 || i == 3 || i == 8) return 32'h1122_3344;
    return 32'h9E37_79B9 * i;
  endfunction

  // Memory responder: write on mem_we, read data valid the cycle after mem_re.
  initial begin
    for (int i = 0; i < 256; i++) dev_mem[i] = init_word(i);
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_we) dev_mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_re) mem_rdata <= dev_mem[mem_addr[9:2]];
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: memory as an array of words, stores as lane
  // mask-and-insert arithmetic; returns what the DUT must do.
  function automatic exp_t model(input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] old;
    logic [31:0] mask;
    int          sh;
    e.err  = 1'b0;
    e.rd   = 1'b0;
    e.addr = {addr[31:2], 2'b00};
    e.data = 32'h0;
    e.acc  = 0;
    old    = ref_mem[addr[9:2]];
    case (size)
      2'b00: begin
        sh     = 8 * int'(addr[1:0]);
        mask   = 32'h0000_00FF << sh;
        e.data = (old & ~mask) | ((wdata & 32'h0000_00FF) << sh);
        e.rd   = 1'b1;
      end
      2'b01: begin
        if (addr[0]) begin
          e.err = 1'b1;
        end else begin
          sh     = 16 * int'(addr[1]);
          mask   = 32'h0000_FFFF << sh;
          e.data = (old & ~mask) | ((wdata & 32'h0000_FFFF) << sh);
          e.rd   = 1'b1;
        end
      end
      2'b10: begin
        if (addr[1:0] != 2'b00) e.err = 1'b1;
        else e.data = wdata;
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) e.addr = 32'h0;
    else ref_mem[addr[9:2]] = e.data;
    return e;
  endfunction

  // Present a request and hold it until accepted (bounded wait).
  task automatic issue(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int   guard;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    guard     = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: req_ready=0 after 20 cycles, expected 1");
      req_valid = 1'b0;
      return;
    end
    e     = model(size, addr, wdata);
    e.acc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_int("drain_pending", sb_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every done and checks strobes each cycle.
  initial begin
    logic ready_due;
    exp_t e;
    ready_due = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready_due = 1'b0;
      end else begin
        if (ready_due) begin
          check1("ready_after_done", req_ready, 1'b1);
          ready_due = 1'b0;
        end
        if (mem_re && mem_we) check1("re_we_exclusive", 1'b1, 1'b0);
        if (mem_we && !done) check1("we_without_done", done, 1'b1);
        if (mem_re) begin
          if (sb_q.size() == 0) begin
            check1("spurious_read", mem_re, 1'b0);
          end else begin
            check1("read_expected", mem_re, sb_q[0].rd);
            check32("read_addr", mem_addr, sb_q[0].addr);
            check_int("read_cycle", cyc - sb_q[0].acc, 1);
          end
        end
        if (done) begin
          if (sb_q.size() == 0) begin
            check1("spurious_done", done, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check1("err", err, e.err);
            check_int("done_latency", cyc - e.acc, (e.rd ? 3 : 1));
            check32("mem_addr", mem_addr, e.addr);
            if (e.err) begin
              check1("err_no_we", mem_we, 1'b0);
              check1("err_no_re", mem_re, 1'b0);
            end else begin
              check1("mem_we", mem_we, 1'b1);
              check32("mem_wdata", mem_wdata, e.data);
            end
            ready_due = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] saved;
    int          r;
    int          bad;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_size  = 2'b00;
    rst       = 1'b1;
    #1;
    check1("rst_ready", req_ready, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check1("rst_re", mem_re, 1'b0);
    check32("rst_addr", mem_addr, 32'h0);
    check32("rst_wdata", mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check1("ready_before_edge", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check1("ready_after_release", req_ready, 1'b1);

    // Directed cases.
    issue(2'b10, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(2'b00, 32'h0000_0022, 32'hAABB_CCDD);
    issue(2'b01, 32'h0000_000E, 32'h1234_BEEF);
    issue(2'b01, 32'h0000_0004, 32'h1234_BEEF);
    issue(2'b01, 32'h0000_0005, 32'h5555_5555);
    issue(2'b10, 32'h0000_0002, 32'h6666_6666);
    issue(2'b11, 32'h0000_0030, 32'h7777_7777);
    issue(2'b00, 32'h0000_0080, 32'h0000_00AA);
    issue(2'b00, 32'h0000_0081, 32'h0000_00BB);
    issue(2'b00, 32'h0000_0082, 32'h0000_00CC);
    issue(2'b00, 32'h0000_0083, 32'h0000_00DD);
    drain();
    check32("b2b_final_word", dev_mem[32], 32'hDDCC_BBAA);

    // Reset while the sb sits in CAPT: dropped, no write, no done.
    saved = ref_mem[16];
    issue(2'b00, 32'h0000_0041, 32'h0000_0099);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check1("midrst_we", mem_we, 1'b0);
    check1("midrst_done", done, 1'b0);
    check1("midrst_ready", req_ready, 1'b0);
    check1("midrst_re", mem_re, 1'b0);
    check32("midrst_addr", mem_addr, 32'h0);
    sb_q.delete();
    ref_mem[16] = saved;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check1("midrst_ready_held", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check1("midrst_ready_back", req_ready, 1'b1);
    issue(2'b10, 32'h0000_0050, 32'hC0FF_EE00);
    drain();
    check32("midrst_word_untouched", dev_mem[16], saved);

    // Randomized traffic over a small window of words so merges collide.
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) s = 2'b00;
      else if (r < 6) s = 2'b01;
      else if (r < 9) s = 2'b10;
      else s = 2'b11;
      a = 32'h0000_0100 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      if (s == 2'b10 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(s, a, $urandom);
    end
    drain();

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dev_mem[i] !== ref_mem[i]) bad++;
    end
    check_int("mem_image_mismatches", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
